fp_div_flow_ctrl: RTL and testbench

//  Flow-control shell directly upstream and downstream of the fixed-latency FP divider.

---
 rtl/fp_div_flow_ctrl_pkg.sv | 25 ++
 rtl/fp_div_flow_ctrl_fifo.sv | 52 +++++
 rtl/fp_div_flow_ctrl.sv | 157 +++++++++++++++
 tb/tb_fp_div_flow_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_div_flow_ctrl_pkg.sv
// Shared definitions for the FP divider flow-control shell and its FIFOs.
package fp_div_pkg;

  localparam int FP_W      = 32;
  localparam int DIV_LAT   = 8;
  localparam int DIV_DEPTH = 8;
  localparam int DIV_TAGW  = 4;

  // Ceiling log2, used to size pointers and occupancy counters.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // One buffered divider result together with the tag of its operation.
  typedef struct packed {
    logic [FP_W-1:0]     data;
    logic [DIV_TAGW-1:0] tag;
  } div_result_t;

endpackage

// File: rtl/fp_div_flow_ctrl_fifo.sv
// Synchronous FIFO with extra-MSB pointers; full/empty come from the MSB compare.
// A push into a full FIFO is accepted when a pop frees the head slot in the same cycle.
module fp_div_sync_fifo
  import fp_div_pkg::*;
#(
  parameter int WIDTH = FP_W,
  parameter int DEPTH = DIV_DEPTH,
  localparam int AW   = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer advance; both wrap naturally through the extra MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset because empty gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fp_div_flow_ctrl.sv
// Flow-control shell around a fixed-latency, non-stallable FP divider.
// An operation is admitted only when a result slot is reserved for it, so the
// divider can never return a result that has nowhere to go.
module fp_div_flow_ctrl
  import fp_div_pkg::*;
#(
  parameter int LAT   = DIV_LAT,
  parameter int DEPTH = DIV_DEPTH,
  parameter int TAGW  = DIV_TAGW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld,
  output logic            in_rdy,
  input  logic [FP_W-1:0] in_a,
  input  logic [FP_W-1:0] in_b,
  input  logic            in_mod,
  input  logic [TAGW-1:0] in_tag,
  output logic            div_en,
  output logic            div_vldin,
  output logic            div_take_mod,
  output logic [FP_W-1:0] div_src0,
  output logic [FP_W-1:0] div_src1,
  input  logic            div_vldout,
  input  logic [FP_W-1:0] div_out,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [FP_W-1:0] out_data,
  output logic [TAGW-1:0] out_tag,
  output logic            busy,
  output logic            err_ovf
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW+1:0] RESV_MAX = (AW + 2)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fp_div_flow_ctrl: DEPTH must be a power of two >= 2");
  end
  if (LAT < 1) begin : g_bad_lat
    $error("fp_div_flow_ctrl: LAT must be at least 1");
  end

  logic [AW:0]      inflight;
  logic [AW:0]      fifo_cnt;
  logic [AW+1:0]    resv;
  logic             issue;
  logic             pop;
  logic             ret_dec;
  logic             ret_err;
  logic             ret_write;
  logic             data_full;
  logic             data_empty;
  logic [FP_W-1:0]  data_head;
  logic [TAGW-1:0]  tag_head;
  logic             tag_full;
  logic             tag_empty;
  logic [AW:0]      tag_cnt;
  logic             tag_unused;
  logic             en_q;
  logic             mod_q;
  logic [FP_W-1:0]  src0_q;
  logic [FP_W-1:0]  src1_q;
  logic             err_q;

  // Slot reservation: everything issued but not yet consumed holds a slot.
  assign resv    = {1'b0, inflight} + {1'b0, fifo_cnt};
  assign out_vld = !data_empty;
  assign pop     = out_vld && out_rdy;
  assign in_rdy  = (resv < RESV_MAX) || pop;
  assign issue   = in_vld && in_rdy;

  // A return is illegal with nothing in flight, or when it would overflow the FIFO.
  assign ret_err   = div_vldout && ((data_full && !pop) || (inflight == '0));
  assign ret_write = div_vldout && !ret_err;
  assign ret_dec   = div_vldout && (inflight != '0);

  assign div_en       = en_q;
  assign div_vldin    = issue;
  assign div_src0     = issue ? in_a   : src0_q;
  assign div_src1     = issue ? in_b   : src1_q;
  assign div_take_mod = issue ? in_mod : mod_q;

  assign out_data   = out_vld ? data_head : '0;
  assign out_tag    = out_vld ? tag_head  : '0;
  assign busy       = (inflight != '0) || out_vld;
  assign err_ovf    = err_q;
  assign tag_unused = ^{tag_full, tag_empty, tag_cnt};

  // Divider enable comes up on the first clock after reset releases.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) en_q <= 1'b0;
    else     en_q <= 1'b1;
  end

  // In-flight count; a simultaneous issue and return cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else if (issue && !ret_dec) begin
      inflight <= inflight + CNT_ONE;
    end else if (ret_dec && !issue) begin
      inflight <= inflight - CNT_ONE;
    end
  end

  // Hold the last issued operands so the divider inputs stay quiet between issues.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src0_q <= '0;
      src1_q <= '0;
      mod_q  <= 1'b0;
    end else if (issue) begin
      src0_q <= in_a;
      src1_q <= in_b;
      mod_q  <= in_mod;
    end
  end

  // Sticky overflow / spurious-return flag, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          err_q <= 1'b0;
    else if (ret_err) err_q <= 1'b1;
  end

  fp_div_sync_fifo #(
    .WIDTH (FP_W),
    .DEPTH (DEPTH)
  ) u_data_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (ret_write),
    .pop   (pop),
    .wdata (div_out),
    .rdata (data_head),
    .full  (data_full),
    .empty (data_empty),
    .count (fifo_cnt)
  );

  fp_div_sync_fifo #(
    .WIDTH (TAGW),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (issue),
    .pop   (pop),
    .wdata (in_tag),
    .rdata (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_cnt)
  );

endmodule

// File: tb/tb_fp_div_flow_ctrl.sv
// Scoreboard bench for fp_div_flow_ctrl with a delay-line divider model.
module tb_fp_div_flow_ctrl;
  import fp_div_pkg::*;

  localparam int LAT   = 8;
  localparam int DEPTH = 8;
  localparam int TAGW  = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_vld = 1'b0;
  logic            in_rdy;
  logic [31:0]     in_a = '0;
  logic [31:0]     in_b = '0;
  logic            in_mod = 1'b0;
  logic [TAGW-1:0] in_tag = '0;
  logic            div_en;
  logic            div_vldin;
  logic            div_take_mod;
  logic [31:0]     div_src0;
  logic [31:0]     div_src1;
  logic            div_vldout;
  logic [31:0]     div_out;
  logic            out_vld;
  logic            out_rdy = 1'b0;
  logic [31:0]     out_data;
  logic [TAGW-1:0] out_tag;
  logic            busy;
  logic            err_ovf;
  logic            inject = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [31:0]     data;
    logic [TAGW-1:0] tag;
    int              cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;
  logic        last_mod = 1'b0;
  bit          exp_err = 1'b0;

  logic        pipe_v [LAT];
  logic [31:0] pipe_d [LAT];

  fp_div_flow_ctrl #(.LAT(LAT), .DEPTH(DEPTH), .TAGW(TAGW)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_vld       (in_vld),
    .in_rdy       (in_rdy),
    .in_a         (in_a),
    .in_b         (in_b),
    .in_mod       (in_mod),
    .in_tag       (in_tag),
    .div_en       (div_en),
    .div_vldin    (div_vldin),
    .div_take_mod (div_take_mod),
    .div_src0     (div_src0),
    .div_src1     (div_src1),
    .div_vldout   (div_vldout),
    .div_out      (div_out),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy),
    .out_data     (out_data),
    .out_tag      (out_tag),
    .busy         (busy),
    .err_ovf      (err_ovf)
  );

  always #5 clk = ~clk;

  // Stand-in for the divider datapath: a fixed mix of the operand bit patterns.
  function automatic logic [31:0] div_ref(input logic [31:0] a, input logic [31:0] b, input logic m);
    return {a[31:16] ^ b[15:0], b[31:16] ^ a[15:0]} ^ {31'b0, m};
  endfunction

  // Divider model: LAT-stage delay line, cleared together with the DUT.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_d[i] <= '0;
      end
    end else if (div_en) begin
      pipe_v[0] <= div_vldin;
      pipe_d[0] <= div_ref(div_src0, div_src1, div_take_mod);
      for (int i = 1; i < LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign div_vldout = pipe_v[LAT-1] | inject;
  assign div_out    = inject ? 32'hDEAD_BEEF : pipe_d[LAT-1];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: predicts handshakes from outstanding-op bookkeeping and checks results in order.
  always @(negedge clk) begin : monitor
    int occ;
    bit exp_vld;
    bit exp_pop;
    bit exp_rdy;
    bit exp_iss;
    if (mon_en && !rst) begin
      occ     = sb_q.size();
      exp_vld = (occ > 0) && (cyc >= sb_q[0].cyc + LAT + 1);
      exp_pop = exp_vld && out_rdy;
      exp_rdy = (occ < DEPTH) || exp_pop;
      exp_iss = in_vld && exp_rdy;
      checkOutput("out_vld", out_vld, exp_vld);
      checkOutput("in_rdy", in_rdy, exp_rdy);
      checkOutput("busy", busy, occ > 0);
      checkOutput("err_ovf", err_ovf, exp_err);
      checkOutput("div_en", div_en, 1);
      checkOutput("div_vldin", div_vldin, exp_iss);
      if (exp_iss) begin
        last_a   = in_a;
        last_b   = in_b;
        last_mod = in_mod;
      end
      checkOutput("div_src0", div_src0, last_a);
      checkOutput("div_src1", div_src1, last_b);
      checkOutput("div_take_mod", div_take_mod, last_mod);
      if (exp_vld && out_vld) begin
        checkOutput("out_data", out_data, sb_q[0].data);
        checkOutput("out_tag", out_tag, sb_q[0].tag);
      end
      if (exp_pop) void'(sb_q.pop_front());
      if (exp_iss) sb_q.push_back('{data: div_ref(in_a, in_b, in_mod), tag: in_tag, cyc: cyc});
      if (inject) exp_err = 1'b1;
    end
  end

  // One cycle of input drive; reports whether the pair was taken.
  task automatic applyStimulus(input bit vld, input logic [31:0] a, input logic [31:0] b,
                               input bit m, input logic [TAGW-1:0] tag, output bit acc);
    in_vld = vld;
    in_a   = a;
    in_b   = b;
    in_mod = m;
    in_tag = tag;
    @(negedge clk);
    acc = in_vld && in_rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic send_op(input logic [31:0] a, input logic [31:0] b, input bit m, input logic [TAGW-1:0] tag);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 100) begin
      applyStimulus(1'b1, a, b, m, tag, acc);
      n++;
    end
    in_vld = 1'b0;
    if (!acc) begin
      errors++;
      $display("[TB] FAIL send_op timeout: tag %0d not accepted within 100 cycles", tag);
    end
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(1'b0, in_a, in_b, in_mod, in_tag, acc);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain timeout: %0d results outstanding, required 0", sb_q.size());
    end
  endtask

  task automatic reset_dut();
    mon_en  = 1'b0;
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    inject  = 1'b0;
    rst     = 1'b1;
    sb_q.delete();
    last_a   = '0;
    last_b   = '0;
    last_mod = 1'b0;
    exp_err  = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_rdy", in_rdy, 1);
    checkOutput("rst_out_vld", out_vld, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err_ovf", err_ovf, 0);
    checkOutput("rst_div_en", div_en, 0);
    checkOutput("rst_div_src0", div_src0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("div_en_after_rst", div_en, 1);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
  endtask

  initial begin
    bit acc;
    int idx;

    $display("[TB] start");
    reset_dut();

    // Single operation: 6.0 / 2.0 with tag 5.
    out_rdy = 1'b1;
    send_op(32'h40C0_0000, 32'h4000_0000, 1'b0, 4'd5);
    wait_drain(50);

    // Backpressure: with the consumer stalled only DEPTH ops get in.
    out_rdy = 1'b0;
    idx = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, $urandom(), $urandom(), 1'($urandom_range(0, 1)), idx[TAGW-1:0], acc);
      if (acc) idx++;
    end
    checkOutput("bp_accepted", idx, DEPTH);
    out_rdy = 1'b1;
    for (int n = 0; n < 200 && idx < 20; n++) begin
      applyStimulus(1'b1, $urandom(), $urandom(), 1'($urandom_range(0, 1)), idx[TAGW-1:0], acc);
      if (acc) idx++;
    end
    in_vld = 1'b0;
    checkOutput("bp_total", idx, 20);
    wait_drain(200);

    // Full occupancy with issue, return and pop in one cycle.
    out_rdy = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_op($urandom(), $urandom(), 1'b0, 4'(i));
    idle(1);
    out_rdy = 1'b1;
    applyStimulus(1'b1, $urandom(), $urandom(), 1'b1, 4'hA, acc);
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    checkOutput("corner_issue", acc, 1);
    idle(LAT + 2);
    out_rdy = 1'b1;
    wait_drain(100);

    // Streaming with random valid; consumer always ready, then random.
    for (int i = 0; i < 400; i++) begin
      if (i >= 200) out_rdy = 1'($urandom_range(0, 1));
      applyStimulus($urandom_range(0, 3) != 0, $urandom(), $urandom(),
                    1'($urandom_range(0, 1)), 4'($urandom()), acc);
    end
    in_vld  = 1'b0;
    out_rdy = 1'b1;
    wait_drain(200);

    // Spurious divider return with nothing in flight.
    out_rdy = 1'b0;
    for (int i = 0; i < 3; i++) send_op($urandom(), $urandom(), 1'b0, 4'(12 + i));
    idle(LAT + 3);
    inject = 1'b1;
    idle(1);
    inject = 1'b0;
    idle(4);
    checkOutput("fault_err_sticky", err_ovf, 1);
    out_rdy = 1'b1;
    wait_drain(50);
    idle(3);

    // Reset while operations are in flight and results are buffered.
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_op($urandom(), $urandom(), 1'b0, 4'(i));
    idle(LAT + 2);
    reset_dut();
    idle(LAT + 3);
    out_rdy = 1'b1;
    send_op(32'h3F80_0000, 32'h4040_0000, 1'b1, 4'd9);
    wait_drain(50);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL global timeout reached");
    $fatal(1, "[TB] timeout");
  end

endmodule
